// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns shared with the display decoder, plus readback FSM states
package seg_pkg;
  typedef enum logic [1:0] {TRACK, LOCKED} state_t;
  // Active-low patterns, bit 6 = g ... bit 0 = a, indexed by hex value
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg_pattern_to_nibble.sv
// seg_pattern_to_nibble: maps an active-low 7-segment pattern back to its hex digit
module seg_pattern_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o,
  output logic       is_blank_o
);
  always_comb begin
    nibble_o = '0;
    is_hex_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_HEX[i]) begin
        nibble_o = 4'(i);
        is_hex_o = 1'b1;
      end
    end
  end
  assign is_blank_o = seg_i == SEG_BLANK;
endmodule

// File: rtl/seg_readback.sv
// seg_readback: recovers per-digit hex values from a multiplexed active-low 7-segment bus
module seg_readback
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segIn,
  input  logic [NUM_DIGITS-1:0]   digitSel,
  input  logic                    errClr,
  output logic [4*NUM_DIGITS-1:0] valueOut,
  output logic [NUM_DIGITS-1:0]   digitValid,
  output logic                    updatePulse,
  output logic                    errorFlag,
  output logic                    frameDone
);
  logic [6:0] seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0] sel_q, prev_sel_q, seen_q, valid_q, seen_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [7:0] stab_q;
  state_t state_q;
  logic pulse_q, err_q, done_q;
  logic [3:0] nib;
  logic is_hex, is_blank, same, one_hot, capture;

  seg_pattern_to_nibble u_map (
    .seg_i     (seg_q),
    .nibble_o  (nib),
    .is_hex_o  (is_hex),
    .is_blank_o(is_blank)
  );

  assign same    = {seg_q, sel_q} == {prev_seg_q, prev_sel_q};
  assign one_hot = sel_q != '0 && (sel_q & (sel_q - NUM_DIGITS'(1))) == '0;
  // Zero or multi-hot selects still lock the window but never capture
  assign capture = state_q == TRACK && same && stab_q == 8'(STABLE_CYCLES - 1) && one_hot;
  assign seen_d  = seen_q | sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q      <= '0;
      sel_q      <= '0;
      prev_seg_q <= '0;
      prev_sel_q <= '0;
      seen_q     <= '0;
      valid_q    <= '0;
      value_q    <= '0;
      stab_q     <= '0;
      state_q    <= TRACK;
      pulse_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      seg_q      <= segIn;
      sel_q      <= digitSel;
      prev_seg_q <= seg_q;
      prev_sel_q <= sel_q;
      pulse_q    <= capture;
      done_q     <= capture && (&seen_d);
      err_q      <= (capture && !is_hex && !is_blank) || (err_q && !errClr);
      if (capture) seen_q <= (&seen_d) ? '0 : seen_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_q[i]) begin
          valid_q[i] <= is_hex;
          if (is_hex) value_q[4*i +: 4] <= nib;
        end
      end
      if (!same) begin
        state_q <= TRACK;
        stab_q  <= '0;
      end else if (state_q == TRACK) begin
        stab_q <= stab_q == 8'hff ? stab_q : stab_q + 8'd1;
        if (stab_q == 8'(STABLE_CYCLES - 1)) state_q <= LOCKED;
      end
    end
  end

  assign valueOut    = value_q;
  assign digitValid  = valid_q;
  assign updatePulse = pulse_q;
  assign errorFlag   = err_q;
  assign frameDone   = done_q;
endmodule

// File: tb/tb_seg_readback.sv
// tb_seg_readback: scoreboard bench; stimulus pushes expected captures, a negedge monitor checks each updatePulse
module tb_seg_readback;
  localparam int ND = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic errClr = 1'b0;
  logic [6:0] segIn = 7'b1111111;
  logic [ND-1:0] digitSel = '0;
  logic [4*ND-1:0] valueOut;
  logic [ND-1:0] digitValid;
  logic updatePulse, errorFlag, frameDone;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  valid;
    logic        err;
    logic        done;
    int          at;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int vectors = 0, miscompares = 0, cyc = 0, pulses = 0, dones = 0, p0;

  seg_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .segIn      (segIn),
    .digitSel   (digitSel),
    .errClr     (errClr),
    .valueOut   (valueOut),
    .digitValid (digitValid),
    .updatePulse(updatePulse),
    .errorFlag  (errorFlag),
    .frameDone  (frameDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A capture is expected 6 cycles after the input changes
  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n, input bit cap = 1'b0,
                       input logic [15:0] v = '0, input logic [3:0] vl = '0,
                       input logic er = 1'b0, input logic dn = 1'b0);
    @(negedge clk);
    segIn = s;
    digitSel = d;
    if (cap) q.push_back('{v, vl, er, dn, cyc + 6});
    repeat (n - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (updatePulse === 1'b1) pulses++;
    if (frameDone === 1'b1) dones++;
    if (updatePulse === 1'b1) begin
      if (q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        e_m = q.pop_front();
        check("valueOut", valueOut, e_m.value);
        check("digitValid", digitValid, e_m.valid);
        check("errorFlag_at_pulse", errorFlag, e_m.err);
        check("frameDone_at_pulse", frameDone, e_m.done);
        check("pulse_cycle", cyc, e_m.at);
      end
    end else if (frameDone === 1'b1) check("stray_frameDone", 1, 0);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valueOut", valueOut, 0);
    check("rst_digitValid", digitValid, 0);
    check("rst_updatePulse", updatePulse, 0);
    check("rst_errorFlag", errorFlag, 0);
    check("rst_frameDone", frameDone, 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("idle_pulses", pulses, 0);
    check("idle_outputs", {valueOut, digitValid, errorFlag, frameDone}, 0);
    // Single digit held long: exactly one capture
    drive(7'b0110000, 4'b0100, 30, 1, 16'h0300, 4'b0100, 0, 0);
    drive(7'b1111111, 4'b0000, 2);
    // Full scan with blanking gaps
    drive(7'b1111001, 4'b0001, 8, 1, 16'h0301, 4'b0101, 0, 0);
    drive(7'b1111111, 4'b0000, 2);
    drive(7'b0000011, 4'b0010, 8, 1, 16'h03B1, 4'b0111, 0, 0);
    drive(7'b1111111, 4'b0000, 2);
    drive(7'b1000110, 4'b0100, 8, 1, 16'h0CB1, 4'b0111, 0, 0);
    drive(7'b1111111, 4'b0000, 2);
    drive(7'b0001110, 4'b1000, 8, 1, 16'hFCB1, 4'b1111, 0, 1);
    drive(7'b1111111, 4'b0000, 2);
    #1;
    check("frame_count", dones, 1);
    // Invalid pattern, then clear, then clear colliding with a new invalid capture
    drive(7'b1010101, 4'b0001, 8, 1, 16'hFCB1, 4'b1110, 1, 0);
    check("err_sticky", errorFlag, 1);
    check("err_valid0", digitValid[0], 0);
    drive(7'b1111111, 4'b0000, 2);
    @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    check("err_cleared", errorFlag, 0);
    drive(7'b1010101, 4'b0001, 1, 1, 16'hFCB1, 4'b1110, 1, 0);
    repeat (5) @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    repeat (3) @(negedge clk);
    check("err_capture_wins", errorFlag, 1);
    drive(7'b1111111, 4'b0000, 2);
    // Short glitches and a multi-hot select never capture
    #1;
    p0 = pulses;
    for (int i = 0; i < 8; i++) drive(i % 2 ? 7'b0010010 : 7'b0000010, 4'b0010, 3);
    drive(7'b0100100, 4'b0011, 20);
    #1;
    check("no_capture_pulses", pulses, p0);
    check("no_capture_value", valueOut, 16'hFCB1);
    // Reset two-thirds into a window, then a full fresh window
    drive(7'b1111000, 4'b1000, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {valueOut, digitValid, updatePulse, errorFlag, frameDone}, 0);
    reset = 1'b0;
    q.push_back('{16'h7000, 4'b1000, 1'b0, 1'b0, cyc + 6});
    repeat (12) @(negedge clk);
    #1;
    check("pending_captures", q.size(), 0);
    check("total_frames", dones, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg_readback.md
# seg_readback

Recovers hex digit values from a multiplexed, active-low 7-segment display bus: the inverse of the 4-bit-to-segment decoder that drives the board displays. It sits beside the display driver and watches the segment lines and digit-select lines. For each digit it waits for the pattern to hold steady, maps the pattern back to a 4-bit value, and stores the value per digit. Self-check logic and the prime-prediction display path use it for on-chip readback.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- segIn  in  7  segment lines, active-low; bit 0 = a … bit 6 = g
- digitSel  in  NUM_DIGITS  digit enables, active-high, one-hot when driving
- errClr  in  1  clears sticky errorFlag
- valueOut  out  4*NUM_DIGITS  recovered nibbles; digit i at [4i+3:4i]
- digitValid  out  NUM_DIGITS  digit i holds a decoded hex value
- updatePulse  out  1  one-cycle strobe on each capture
- errorFlag  out  1  sticky: an unrecognised pattern was captured
- frameDone  out  1  one-cycle strobe when every digit has been captured since the last frameDone

## Operation
- Input stage: segIn and digitSel are registered once into sampSeg and sampSel. All logic works on the sampled values.
- Pattern map, segIn to nibble:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0011000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - 1111111 = blank. Any other pattern is invalid.
- FSM, 2-bit state, TRACK / LOCKED:
  - TRACK: stabCnt increments each cycle while {sampSeg,sampSel} equals the previous sample. On any difference, stabCnt reloads to 0.
  - TRACK → LOCKED: when stabCnt reaches STABLE_CYCLES-1 with the sample still equal, capture is performed.
  - LOCKED: no further captures. Any difference in {sampSeg,sampSel} → TRACK, stabCnt=0.
- Capture, only when sampSel is one-hot (selected index k):
  - hex pattern: valueOut[k] updates, digitValid[k]=1, seenMask[k]=1, updatePulse=1.
  - blank: digitValid[k]=0, valueOut[k] unchanged, seenMask[k]=1, updatePulse=1.
  - invalid: errorFlag=1, digitValid[k]=0, seenMask[k]=1, updatePulse=1.
- sampSel zero or multi-hot: the FSM still enters LOCKED, but nothing is captured and no pulse is issued. This covers the inter-digit blanking gap.
- frameDone: asserted when seenMask becomes all-ones. seenMask clears in the same cycle.
- errClr: clears errorFlag. If an invalid capture occurs in the same cycle as errClr, the capture wins and errorFlag stays 1.
- stabCnt width: 8 bits. It saturates and never wraps.

## Timing
- Reset values, applied one cycle after reset is sampled high:
  - valueOut = 0, digitValid = 0, updatePulse = 0, errorFlag = 0, frameDone = 0
  - state = TRACK, stabCnt = 0, seenMask = 0, sample registers = 0
- Reset mid-operation aborts any pending capture. Reset has priority over errClr and capture.
- Latency: inputs change to a new steady value at edge t. updatePulse is high during the cycle after edge t+STABLE_CYCLES+1. valueOut and digitValid update on that same edge.
- frameDone is coincident with the updatePulse of the final digit.
- A change of any single input bit for one cycle restarts the window. Glitches shorter than STABLE_CYCLES cycles never capture.
- At most one capture per steady window. A digit held indefinitely yields exactly one updatePulse.

## Structure
- Shared package seg_pkg holds:
  - the 16 segment pattern constants and the SEG_BLANK constant, also used by the display decoder
  - the FSM state constants TRACK and LOCKED
- Sub-module seg_pattern_to_nibble: combinational; seg[6:0] → nibble[3:0], isHex, isBlank.
- Top level holds the sample registers, stabCnt, FSM, per-digit storage, seenMask and flags.

## Test plan
- Reset, then idle bus (segIn=1111111, digitSel=0): all outputs 0 and no pulses for 100 cycles.
- NUM_DIGITS=4, STABLE_CYCLES=4; drive digit 2 with 0110000 for 10 cycles → one updatePulse 6 cycles after the change; valueOut[11:8]=3; digitValid=0100.
- Scan digits 0..3 with 1111001, 0000011, 1000110, 0001110, 8 cycles each, with 2-cycle gaps of digitSel=0 → valueOut=16'hFCB1; digitValid=1111; frameDone once, together with the 4th updatePulse.
- Digit 0 with 1010101 held 8 cycles → errorFlag=1 and digitValid[0]=0. Pulse errClr → errorFlag=0. errClr coincident with another invalid capture → errorFlag stays 1.
- Pattern alternating each 3 cycles (shorter than STABLE_CYCLES) → no updatePulse. digitSel=0011 held 20 cycles → no capture.
- Assert reset for 1 cycle mid-window at stabCnt=2 → all outputs 0 next cycle. The steady input then needs a full STABLE_CYCLES window before capturing.
